// File: rtl/barrier_arrival_serializer.sv
// Serializes per-core barrier arrivals into one barrier-get per cycle and releases cores on counter events.
// Optional status outputs (pending/waiting masks, arrival count) are enabled by EU_BARRIER_SER_STATUS_EN.
module barrier_arrival_serializer #(
    parameter int NUM_CORES = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_CORES-1:0]          core_barrier_req_i,
    input  logic                          clear_req_i,
    input  logic                          err_clr_i,
    input  logic [NUM_CORES-1:0]          barrier_event_i,
    output logic                          barrier_get_o,
    output logic                          clear_req_o,
    output logic [NUM_CORES-1:0]          core_wait_o,
    output logic [NUM_CORES-1:0]          core_release_o,
    output logic                          err_o
`ifdef EU_BARRIER_SER_STATUS_EN
    ,
    output logic [NUM_CORES-1:0]          pending_mask_o,
    output logic [NUM_CORES-1:0]          waiting_mask_o,
    output logic [$clog2(NUM_CORES):0]    arrivals_o
`endif
);

    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PW-1:0] PTR_RST = PW'(NUM_CORES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WAITING = 2'd2
    } state_t;

    state_t                 state_q [NUM_CORES];
    state_t                 state_d [NUM_CORES];
    logic [PW-1:0]          ptr_q;
    logic [NUM_CORES-1:0]   release_q;
    logic                   err_q;

    logic [NUM_CORES-1:0]   idle_vec;
    logic [NUM_CORES-1:0]   pend_vec;
    logic [NUM_CORES-1:0]   wait_vec;
    logic [NUM_CORES-1:0]   grant;
    logic [PW-1:0]          grant_idx;
    logic                   grant_en;
    logic                   err_set;
    logic [NUM_CORES-1:0]   release_d;

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            idle_vec[c] = (state_q[c] == ST_IDLE);
            pend_vec[c] = (state_q[c] == ST_PENDING);
            wait_vec[c] = (state_q[c] == ST_WAITING);
        end
    end

    // The counter's self-clear beats its increment, so never grant while any event is live.
    assign grant_en = !rst_i && !clear_req_i && (barrier_event_i == '0);

    always_comb begin
        int  idx;
        logic found;
        grant     = '0;
        grant_idx = ptr_q;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (grant_en && !found && pend_vec[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CORES; c++) begin
            state_d[c] = state_q[c];
            if (clear_req_i) begin
                state_d[c] = ST_IDLE;
            end else begin
                case (state_q[c])
                    ST_IDLE:    if (core_barrier_req_i[c]) state_d[c] = ST_PENDING;
                    ST_PENDING: if (grant[c])              state_d[c] = ST_WAITING;
                    ST_WAITING: if (barrier_event_i[c])    state_d[c] = ST_IDLE;
                    default:                               state_d[c] = ST_IDLE;
                endcase
            end
        end
        // Events on PENDING cores belong to the next episode and are silently ignored.
        err_set   = !clear_req_i &&
                    (((core_barrier_req_i & ~idle_vec) != '0) ||
                     ((barrier_event_i & idle_vec) != '0));
        release_d = clear_req_i ? '0 : (barrier_event_i & wait_vec);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CORES; c++) state_q[c] <= ST_IDLE;
            ptr_q     <= PTR_RST;
            release_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CORES; c++) state_q[c] <= state_d[c];
            if (grant != '0) ptr_q <= grant_idx;
            release_q <= release_d;
            if (err_set)        err_q <= 1'b1;
            else if (err_clr_i) err_q <= 1'b0;
        end
    end

    assign barrier_get_o  = (grant != '0);
    assign clear_req_o    = clear_req_i;
    assign core_wait_o    = ~idle_vec;
    assign core_release_o = release_q;
    assign err_o          = err_q;

`ifdef EU_BARRIER_SER_STATUS_EN
    localparam int AW = $clog2(NUM_CORES) + 1;
    logic [AW-1:0] arrivals_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_req_i || (barrier_event_i != '0)) begin
            arrivals_q <= '0;
        end else if ((grant != '0) && (arrivals_q != AW'(NUM_CORES))) begin
            arrivals_q <= arrivals_q + 1'b1;
        end
    end

    assign pending_mask_o = pend_vec;
    assign waiting_mask_o = wait_vec;
    assign arrivals_o     = arrivals_q;
`endif

endmodule

// File: tb/tb_barrier_arrival_serializer.sv
// Directed table-driven bench for barrier_arrival_serializer with a few hand-written corner sequences.
module tb_barrier_arrival_serializer;

    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [N-1:0] core_barrier_req_i;
    logic         clear_req_i;
    logic         err_clr_i;
    logic [N-1:0] barrier_event_i;
    logic         barrier_get_o;
    logic         clear_req_o;
    logic [N-1:0] core_wait_o;
    logic [N-1:0] core_release_o;
    logic         err_o;
`ifdef EU_BARRIER_SER_STATUS_EN
    logic [N-1:0]         pending_mask_o;
    logic [N-1:0]         waiting_mask_o;
    logic [$clog2(N):0]   arrivals_o;
`endif

    barrier_arrival_serializer #(.NUM_CORES(N)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .core_barrier_req_i (core_barrier_req_i),
        .clear_req_i        (clear_req_i),
        .err_clr_i          (err_clr_i),
        .barrier_event_i    (barrier_event_i),
        .barrier_get_o      (barrier_get_o),
        .clear_req_o        (clear_req_o),
        .core_wait_o        (core_wait_o),
        .core_release_o     (core_release_o),
        .err_o              (err_o)
`ifdef EU_BARRIER_SER_STATUS_EN
        ,
        .pending_mask_o     (pending_mask_o),
        .waiting_mask_o     (waiting_mask_o),
        .arrivals_o         (arrivals_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         clr;
        logic         eclr;
        logic [N-1:0] ev;
        logic         get;
        logic [N-1:0] wt;
        logic [N-1:0] rel;
        logic         err;
        logic         clro;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic [N-1:0] req, input logic clr, input logic eclr,
                       input logic [N-1:0] ev, input logic get, input logic [N-1:0] wt,
                       input logic [N-1:0] rel, input logic err, input logic clro);
        vec_t v;
        v = '{rst, req, clr, eclr, ev, get, wt, rel, err, clro};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b expected %b", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] req, input logic clr,
                         input logic eclr, input logic [N-1:0] ev);
        @(posedge clk_i);
        #1;
        rst_i              = rst;
        core_barrier_req_i = req;
        clear_req_i        = clr;
        err_clr_i          = eclr;
        barrier_event_i    = ev;
        @(negedge clk_i);
    endtask

    task automatic check_all(input int row, input logic get, input logic [N-1:0] wt,
                             input logic [N-1:0] rel, input logic err, input logic clro);
        chk("barrier_get", row, {3'b0, barrier_get_o}, {3'b0, get});
        chk("core_wait",   row, core_wait_o, wt);
        chk("core_release",row, core_release_o, rel);
        chk("err",         row, {3'b0, err_o}, {3'b0, err});
        chk("clear_req_o", row, {3'b0, clear_req_o}, {3'b0, clro});
    endtask

    initial begin
        rst_i = 1'b1; core_barrier_req_i = '0; clear_req_i = 1'b0;
        err_clr_i = 1'b0; barrier_event_i = '0;

        //   rst req     clr eclr ev      get wt      rel     err clro
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0); // reset state, ptr=3
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0); // simultaneous arrivals
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, 0); // grant 0
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, 0); // grant 1
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, 0); // grant 2
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1111, 4'b0000, 0, 0); // grant 3
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b1111, 4'b0000, 0, 0); // exactly four pulses
        add(0, 4'b0000, 0, 0, 4'b1111, 0, 4'b1111, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1111, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0); // single core
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0001, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0001, 0, 4'b0001, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0001, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0011, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0); // ptr=0: core1 first
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0011, 4'b0000, 0, 0);
        add(0, 4'b1100, 0, 0, 4'b0000, 1, 4'b0011, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0011, 0, 4'b1111, 4'b0000, 0, 0); // grant inhibit
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1100, 4'b0011, 0, 0); // core 2
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1100, 4'b0000, 0, 0); // core 3
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b1100, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b1100, 0, 4'b1100, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b1100, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0010, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0); // double request
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b0010, 4'b0000, 0, 0);
        add(0, 4'b0010, 0, 0, 4'b0000, 0, 4'b0010, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0010, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 1, 0);
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 4'b0010, 4'b0000, 0, 0); // abort setup
        add(0, 4'b0100, 0, 0, 4'b0000, 1, 4'b0011, 4'b0000, 0, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0111, 4'b0000, 0, 1); // clear
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0, 0); // event on idle core
        add(0, 4'b0000, 0, 1, 4'b0010, 0, 4'b0000, 4'b0000, 1, 0); // set beats clear
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0);
        add(0, 4'b0111, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 4'b0111, 4'b0000, 0, 0); // reset mid-operation
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b1001, 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1001, 4'b0000, 0, 0); // ptr=3: core0 first
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 4'b1001, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 4'b1001, 4'b0000, 0, 0);

        repeat (2) @(posedge clk_i);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].clr, vecs[i].eclr, vecs[i].ev);
            check_all(i, vecs[i].get, vecs[i].wt, vecs[i].rel, vecs[i].err, vecs[i].clro);
        end

        // Request from core 0 in the same cycle as its release event.
        drive(0, 4'b0001, 0, 0, 4'b0001);
        check_all(100, 0, 4'b1001, 4'b0000, 0, 0);
        drive(0, 4'b0000, 0, 0, 4'b0000);
        check_all(101, 0, 4'b1000, 4'b0001, 1, 0);
        drive(0, 4'b0000, 0, 1, 4'b0000);
        check_all(102, 0, 4'b1000, 4'b0000, 1, 0);
`ifdef EU_BARRIER_SER_STATUS_EN
        chk("waiting_mask", 102, waiting_mask_o, 4'b1000);
        chk("arrivals", 102, {1'b0, arrivals_o}, 4'd0);
`endif

        // Clear and a release event in the same cycle: no release pulse.
        drive(0, 4'b0000, 1, 0, 4'b1000);
        check_all(103, 0, 4'b1000, 4'b0000, 0, 1);
        drive(0, 4'b0000, 0, 0, 4'b0000);
        check_all(104, 0, 4'b0000, 4'b0000, 0, 0);

`ifdef EU_BARRIER_SER_STATUS_EN
        // Arrival count climbs to four and saturates.
        drive(0, 4'b1111, 0, 0, 4'b0000);
        repeat (6) drive(0, 4'b0000, 0, 0, 4'b0000);
        chk("arrivals_sat", 105, {1'b0, arrivals_o}, 4'd4);
        chk("pending_mask", 105, pending_mask_o, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
